stage_mem_ctrl: RTL

Sequencer and write arbiter for the stage memory bank: tap memory (192-bit × 16), bias memory (32-bit × 8) and data memory (32-bit × 64). On `start` it walks a configured rows × cols job. Each row issues one bias read followed by `cols` paired tap/data reads. Every issued read gets a tag that is aligned with the one-cycle memory read latency, so the downstream MAC datapath can consume the read data. Host write requests share the same memory ports, take priority, and stall the sequencer.

---
 rtl/stage_mem_ctrl_if.sv | 65 ++++++
 rtl/stage_mem_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem_ctrl_if.sv
// Bundle of the stage_mem_ctrl control, host-write, memory-port and tag
// signals. The master side is the host / job controller plus the memory
// bank consumer; the slave side is the sequencer itself.
interface stage_mem_ctrl_if #(
    parameter int TAP_AW  = 4,
    parameter int BIAS_AW = 3,
    parameter int DATA_AW = 6
);
    // job control
    logic                start;
    logic [3:0]          cfg_rows;
    logic [4:0]          cfg_cols;
    logic                busy;
    logic                done;
    logic                cfg_err;

    // host write request
    logic                wr_valid;
    logic [1:0]          wr_sel;
    logic [5:0]          wr_addr;
    logic [191:0]        wr_data;

    // tap memory port
    logic [TAP_AW-1:0]   tap_addr;
    logic                tap_rd_en;
    logic                tap_wr_en;
    logic [191:0]        tap_wr_data;

    // bias memory port
    logic [BIAS_AW-1:0]  bias_addr;
    logic                bias_rd_en;
    logic                bias_wr_en;
    logic [31:0]         bias_wr_data;

    // data memory port
    logic [DATA_AW-1:0]  data_addr;
    logic                data_rd_en;
    logic                data_wr_en;
    logic [31:0]         data_wr_data;

    // read-data tags, aligned with the one-cycle memory latency
    logic                out_valid;
    logic                out_kind;
    logic                out_first;
    logic                out_last;
    logic [2:0]          out_row;

    modport master (
        output start, cfg_rows, cfg_cols, wr_valid, wr_sel, wr_addr, wr_data,
        input  busy, done, cfg_err,
        input  tap_addr, tap_rd_en, tap_wr_en, tap_wr_data,
        input  bias_addr, bias_rd_en, bias_wr_en, bias_wr_data,
        input  data_addr, data_rd_en, data_wr_en, data_wr_data,
        input  out_valid, out_kind, out_first, out_last, out_row
    );

    modport slave (
        input  start, cfg_rows, cfg_cols, wr_valid, wr_sel, wr_addr, wr_data,
        output busy, done, cfg_err,
        output tap_addr, tap_rd_en, tap_wr_en, tap_wr_data,
        output bias_addr, bias_rd_en, bias_wr_en, bias_wr_data,
        output data_addr, data_rd_en, data_wr_en, data_wr_data,
        output out_valid, out_kind, out_first, out_last, out_row
    );
endinterface

// File: rtl/stage_mem_ctrl.sv
// Sequencer and write arbiter for the stage memory bank. Walks a rows x cols
// job (one bias read, then cols paired tap/data reads per row) and emits a
// tag one cycle after each read so it lines up with the memory read data.
// Host writes share the memory ports, win over reads and stall the walk.
module stage_mem_ctrl #(
    parameter int TAP_AW  = 4,
    parameter int BIAS_AW = 3,
    parameter int DATA_AW = 6
) (
    input  logic           clk,
    input  logic           reset,
    stage_mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BIAS = 2'd1,
        S_MAC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [TAP_AW-1:0]  C_ONE = TAP_AW'(1);
    localparam logic [BIAS_AW-1:0] R_ONE = BIAS_AW'(1);
    localparam logic [DATA_AW-1:0] D_ONE = DATA_AW'(1);

    state_t              state;
    logic [3:0]          rows_q;
    logic [4:0]          cols_q;
    logic [BIAS_AW-1:0]  r_q;
    logic [TAP_AW-1:0]   c_q;
    logic [DATA_AW-1:0]  d_q;
    logic                busy_q;
    logic                done_q;
    logic                cfg_err_q;

    logic                cfg_legal;
    logic                wr_hit;
    logic                stall;
    logic                last_col;
    logic                last_row;

    // issue-stage read strobes
    logic                rd_bias_p0;
    logic                rd_mac_p0;

    // tag registers, one cycle behind the issue stage
    logic                vld_p1;
    logic                kind_p1;
    logic                first_p1;
    logic                last_p1;
    logic [2:0]          row_p1;

    assign cfg_legal = (bus.cfg_rows != 4'd0) && (bus.cfg_rows <= 4'd8) &&
                       (bus.cfg_cols != 5'd0) && (bus.cfg_cols <= 5'd16);

    // Reserved select (3) is dropped entirely, so only 0..2 count as a write.
    assign wr_hit   = bus.wr_valid && (bus.wr_sel != 2'd3);
    assign stall    = wr_hit && ((state == S_BIAS) || (state == S_MAC));
    assign last_col = (5'(c_q) == (cols_q - 5'd1));
    assign last_row = (4'(r_q) == (rows_q - 4'd1));

    // ---- stage p0: read issue ----
    assign rd_bias_p0 = (state == S_BIAS) && !stall;
    assign rd_mac_p0  = (state == S_MAC)  && !stall;

    // Job FSM: owns state, counters and the registered busy/done/cfg_err flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (cfg_legal) begin
                            rows_q <= bus.cfg_rows;
                            cols_q <= bus.cfg_cols;
                            r_q    <= '0;
                            c_q    <= '0;
                            d_q    <= '0;
                            busy_q <= 1'b1;
                            state  <= S_BIAS;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_BIAS: begin
                    if (!stall) begin
                        c_q   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (!stall) begin
                        d_q <= d_q + D_ONE;
                        if (last_col) begin
                            if (last_row) begin
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                r_q   <= r_q + R_ONE;
                                state <= S_BIAS;
                            end
                        end else begin
                            c_q <= c_q + C_ONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port mux: write beats read beats zero. Any write stalls the
    // sequencer, so a read enable and a write enable never share a memory.
    always_comb begin
        bus.tap_addr     = '0;
        bus.tap_rd_en    = 1'b0;
        bus.tap_wr_en    = 1'b0;
        bus.tap_wr_data  = '0;
        bus.bias_addr    = '0;
        bus.bias_rd_en   = 1'b0;
        bus.bias_wr_en   = 1'b0;
        bus.bias_wr_data = '0;
        bus.data_addr    = '0;
        bus.data_rd_en   = 1'b0;
        bus.data_wr_en   = 1'b0;
        bus.data_wr_data = '0;

        if (bus.wr_valid) begin
            case (bus.wr_sel)
                2'd0: begin
                    bus.tap_wr_en   = 1'b1;
                    bus.tap_addr    = bus.wr_addr[TAP_AW-1:0];
                    bus.tap_wr_data = bus.wr_data;
                end
                2'd1: begin
                    bus.bias_wr_en   = 1'b1;
                    bus.bias_addr    = bus.wr_addr[BIAS_AW-1:0];
                    bus.bias_wr_data = bus.wr_data[31:0];
                end
                2'd2: begin
                    bus.data_wr_en   = 1'b1;
                    bus.data_addr    = bus.wr_addr[DATA_AW-1:0];
                    bus.data_wr_data = bus.wr_data[31:0];
                end
                default: begin
                end
            endcase
        end

        if (rd_bias_p0) begin
            bus.bias_rd_en = 1'b1;
            bus.bias_addr  = r_q;
        end
        if (rd_mac_p0) begin
            bus.tap_rd_en  = 1'b1;
            bus.tap_addr   = c_q;
            bus.data_rd_en = 1'b1;
            bus.data_addr  = d_q;
        end
    end

    // ---- stage p1: tag registered alongside the memory read data ----
    // Tag register: cleared by reset so an in-flight tag is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            kind_p1  <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            row_p1   <= '0;
        end else begin
            vld_p1   <= rd_bias_p0 || rd_mac_p0;
            kind_p1  <= rd_mac_p0;
            first_p1 <= rd_mac_p0 && (c_q == '0);
            last_p1  <= rd_mac_p0 && last_col;
            row_p1   <= (rd_bias_p0 || rd_mac_p0) ? 3'(r_q) : 3'd0;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.out_valid = vld_p1;
    assign bus.out_kind  = kind_p1;
    assign bus.out_first = first_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_row   = row_p1;

endmodule
